// File: rtl/wb_load_select.sv
// ---------------------------------------------------------------------------
// wb_load_select
//
// Writeback source selector with a load-alignment path. A request either
// writes back one of the non-load sources (result, link_pc, imm) one cycle
// after acceptance, or, for a load, waits in WAIT_LOAD for the memory word,
// extracts the addressed byte/half/word, sign- or zero-extends it, and
// writes it back one cycle after mem_valid. A load that sees no data for
// TIMEOUT cycles is dropped and flagged as an error.
//
// Parameters
//   WIDTH    data path width (multiple of 16)
//   RADDR_W  destination register address width
//   TIMEOUT  maximum number of WAIT_LOAD cycles (>= 2)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready request handshake; in_ready is high only in IDLE
//   sel               00 result, 01 load, 10 link_pc, 11 imm
//   result/link_pc/imm  non-load sources
//   dest              destination register
//   ld_size           00 byte, 01 half, 1x word
//   ld_signed         sign-extend (1) / zero-extend (0) the load
//   byte_off          byte offset of the load inside the word
//   mem_valid/ldr_data  memory response (only looked at in WAIT_LOAD)
//   wb_valid/wb_we/wb_addr/wb_data  writeback port (one-cycle pulse)
//   err_clr           clears err_sticky
//   err_pulse         high during the WAIT_LOAD cycle that times out
//   err_sticky        a timeout happened since the last clear/reset
// ---------------------------------------------------------------------------
module wb_load_select #(
    parameter int WIDTH   = 32,
    parameter int RADDR_W = 5,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         sel,
    input  logic [WIDTH-1:0]   result,
    input  logic [WIDTH-1:0]   link_pc,
    input  logic [WIDTH-1:0]   imm,
    input  logic [RADDR_W-1:0] dest,
    input  logic [1:0]         ld_size,
    input  logic               ld_signed,
    input  logic [1:0]         byte_off,
    input  logic               mem_valid,
    input  logic [WIDTH-1:0]   ldr_data,
    output logic               wb_valid,
    output logic               wb_we,
    output logic [RADDR_W-1:0] wb_addr,
    output logic [WIDTH-1:0]   wb_data,
    input  logic               err_clr,
    output logic               err_pulse,
    output logic               err_sticky
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic               capture_p0;
    logic               timeout_p0;
    logic               vld_nxt;
    logic [RADDR_W-1:0] addr_nxt;
    logic [WIDTH-1:0]   data_nxt;

    logic [RADDR_W-1:0] ld_dest_p0;
    logic [1:0]         ld_size_p0;
    logic               ld_signed_p0;
    logic [1:0]         ld_off_p0;

    logic               vld_p1;
    logic [RADDR_W-1:0] wb_addr_p1;
    logic [WIDTH-1:0]   wb_data_p1;

    // Pick the addressed byte/half out of the raw word and extend it.
    // The sign bit is prefixed explicitly (0 for unsigned loads), so a single
    // signed assignment performs both sign- and zero-extension.
    function automatic logic [WIDTH-1:0] extend_load(
        input logic [WIDTH-1:0] raw,
        input logic [1:0]       size,
        input logic             sgn,
        input logic [1:0]       off
    );
        logic [WIDTH-1:0]        shifted;
        logic signed [8:0]       byte_s;
        logic signed [16:0]      half_s;
        logic signed [WIDTH-1:0] ext_s;
        shifted = '0;
        byte_s  = '0;
        half_s  = '0;
        ext_s   = signed'(raw);
        case (size)
            2'b00: begin
                shifted = raw >> {off, 3'b000};
                byte_s  = {sgn & shifted[7], shifted[7:0]};
                ext_s   = byte_s;
            end
            2'b01: begin
                // byte_off[0] is deliberately ignored for halves
                shifted = raw >> {off[1], 4'b0000};
                half_s  = {sgn & shifted[15], shifted[15:0]};
                ext_s   = half_s;
            end
            default: begin
                ext_s = signed'(raw);
            end
        endcase
        return ext_s;
    endfunction

    function automatic logic [WIDTH-1:0] select_source(
        input logic [1:0]       s,
        input logic [WIDTH-1:0] res,
        input logic [WIDTH-1:0] lpc,
        input logic [WIDTH-1:0] im
    );
        logic [WIDTH-1:0] v;
        case (s)
            2'b10:   v = lpc;
            2'b11:   v = im;
            default: v = res;
        endcase
        return v;
    endfunction

    // ---- stage p0: request decode / load wait -----------------------------
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        capture_p0 = 1'b0;
        timeout_p0 = 1'b0;
        vld_nxt    = 1'b0;
        addr_nxt   = wb_addr_p1;
        data_nxt   = wb_data_p1;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (sel == 2'b01) begin
                        capture_p0 = 1'b1;
                        cnt_nxt    = '0;
                        state_nxt  = WAIT_LOAD;
                    end else begin
                        vld_nxt  = 1'b1;
                        addr_nxt = dest;
                        data_nxt = select_source(sel, result, link_pc, imm);
                    end
                end
            end
            WAIT_LOAD: begin
                // Data arriving on the last allowed cycle still wins.
                if (mem_valid) begin
                    vld_nxt   = 1'b1;
                    addr_nxt  = ld_dest_p0;
                    data_nxt  = extend_load(ldr_data, ld_size_p0, ld_signed_p0, ld_off_p0);
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout_p0 = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            err_sticky <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // A timeout in the same cycle as a clear leaves the flag set.
            if (timeout_p0) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

    // Load attributes are only consumed in WAIT_LOAD, which is always entered
    // through a capture, so these need no reset.
    always_ff @(posedge clk) begin
        if (capture_p0) begin
            ld_dest_p0   <= dest;
            ld_size_p0   <= ld_size;
            ld_signed_p0 <= ld_signed;
            ld_off_p0    <= byte_off;
        end
    end

    // ---- stage p1: writeback register ------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            wb_addr_p1 <= '0;
            wb_data_p1 <= '0;
        end else begin
            vld_p1     <= vld_nxt;
            wb_addr_p1 <= addr_nxt;
            wb_data_p1 <= data_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign err_pulse = timeout_p0;
    assign wb_valid  = vld_p1;
    assign wb_addr   = wb_addr_p1;
    assign wb_data   = wb_data_p1;
    // Register 0 is hard-wired, so it is never written.
    assign wb_we     = vld_p1 & (|wb_addr_p1);

endmodule

// File: tb/tb_wb_load_select.sv
// ---------------------------------------------------------------------------
// tb_wb_load_select
//
// Directed bench for wb_load_select. A behavioural reference (pending-load
// record with an age, arithmetic byte/half extraction) predicts every output;
// a negedge process compares the DUT against it each cycle, and the stimulus
// thread adds literal checks on hand-computed values.
// ---------------------------------------------------------------------------
module tb_wb_load_select;

    localparam int WIDTH   = 32;
    localparam int RADDR_W = 5;
    localparam int TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         sel;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   link_pc;
    logic [WIDTH-1:0]   imm;
    logic [RADDR_W-1:0] dest;
    logic [1:0]         ld_size;
    logic               ld_signed;
    logic [1:0]         byte_off;
    logic               mem_valid;
    logic [WIDTH-1:0]   ldr_data;
    logic               wb_valid;
    logic               wb_we;
    logic [RADDR_W-1:0] wb_addr;
    logic [WIDTH-1:0]   wb_data;
    logic               err_clr;
    logic               err_pulse;
    logic               err_sticky;

    int total = 0;
    int bad   = 0;
    logic cmp_en = 1'b0;

    wb_load_select #(.WIDTH(WIDTH), .RADDR_W(RADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .result(result), .link_pc(link_pc), .imm(imm), .dest(dest),
        .ld_size(ld_size), .ld_signed(ld_signed), .byte_off(byte_off),
        .mem_valid(mem_valid), .ldr_data(ldr_data),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .err_clr(err_clr), .err_pulse(err_pulse), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_load(input logic [31:0] raw, input logic [1:0] size,
                                             input logic sgn, input logic [1:0] off);
        longint v;
        if (size == 2'd0) begin
            v = (longint'(raw) >> (8 * off)) & 64'hFF;
            if (sgn && v >= 128) v = v - 256;
        end else if (size == 2'd1) begin
            v = (longint'(raw) >> ((off >= 2) ? 16 : 0)) & 64'hFFFF;
            if (sgn && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(raw);
        end
        return v[31:0];
    endfunction

    logic               m_vld;
    logic [RADDR_W-1:0] m_addr;
    logic [31:0]        m_data;
    logic               m_sticky;
    logic               m_pend;
    int                 m_age;       // 1-based index of the current wait cycle
    logic [RADDR_W-1:0] m_dest;
    logic [1:0]         m_size;
    logic               m_sgn;
    logic [1:0]         m_off;
    logic               m_timeout;

    assign m_timeout = m_pend && !mem_valid && (m_age == TIMEOUT);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld    <= 1'b0;
            m_addr   <= '0;
            m_data   <= '0;
            m_sticky <= 1'b0;
            m_pend   <= 1'b0;
            m_age    <= 0;
        end else begin
            m_vld <= 1'b0;
            if (!m_pend) begin
                if (in_valid && sel == 2'b01) begin
                    m_pend <= 1'b1;
                    m_age  <= 1;
                    m_dest <= dest;
                    m_size <= ld_size;
                    m_sgn  <= ld_signed;
                    m_off  <= byte_off;
                end else if (in_valid) begin
                    m_vld  <= 1'b1;
                    m_addr <= dest;
                    m_data <= (sel == 2'b00) ? result : (sel == 2'b10) ? link_pc : imm;
                end
            end else if (mem_valid) begin
                m_vld  <= 1'b1;
                m_addr <= m_dest;
                m_data <= ref_load(ldr_data, m_size, m_sgn, m_off);
                m_pend <= 1'b0;
            end else if (m_age == TIMEOUT) begin
                m_pend <= 1'b0;
            end else begin
                m_age <= m_age + 1;
            end
            if (m_timeout)    m_sticky <= 1'b1;
            else if (err_clr) m_sticky <= 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp in_ready",   in_ready,   !m_pend);
            chk("cmp wb_valid",   wb_valid,   m_vld);
            chk("cmp wb_we",      wb_we,      m_vld && (m_addr != 0));
            chk("cmp wb_addr",    wb_addr,    m_addr);
            chk("cmp wb_data",    wb_data,    m_data);
            chk("cmp err_pulse",  err_pulse,  m_timeout);
            chk("cmp err_sticky", err_sticky, m_sticky);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] s, input logic [RADDR_W-1:0] d, input logic [31:0] v);
        in_valid = 1'b1;
        sel      = s;
        dest     = d;
        result   = (s == 2'b00) ? v : 32'hDEAD_0000;
        link_pc  = (s == 2'b10) ? v : 32'hDEAD_1111;
        imm      = (s == 2'b11) ? v : 32'hDEAD_2222;
    endtask

    task automatic start_load(input logic [1:0] sz, input logic sg, input logic [1:0] off,
                              input logic [RADDR_W-1:0] d);
        tick();
        in_valid  = 1'b1;
        sel       = 2'b01;
        dest      = d;
        ld_size   = sz;
        ld_signed = sg;
        byte_off  = off;
        tick();
        in_valid  = 1'b0;
        ld_size   = 2'b11;
        ld_signed = 1'b0;
        byte_off  = 2'b00;
    endtask

    // Load whose data arrives in wait cycle (extra+1); returns at the negedge
    // after the writeback edge.
    task automatic do_load(input logic [1:0] sz, input logic sg, input logic [1:0] off,
                           input logic [RADDR_W-1:0] d, input logic [31:0] data, input int extra);
        start_load(sz, sg, off, d);
        repeat (extra) tick();
        mem_valid = 1'b1;
        ldr_data  = data;
        tick();
        mem_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0; sel = 2'b00; result = '0; link_pc = '0; imm = '0; dest = '0;
        ld_size = 2'b00; ld_signed = 1'b0; byte_off = 2'b00;
        mem_valid = 1'b0; ldr_data = '0; err_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        @(negedge clk);
        chk("reset wb_valid", wb_valid, 0);
        chk("reset wb_data", wb_data, 0);
        chk("reset in_ready", in_ready, 1);
        chk("reset err_sticky", err_sticky, 0);
        tick();
        rst_n = 1'b1;

        // Non-load writeback, latency 1
        tick();
        req(2'b00, 5'd3, 32'd5);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("alu wb_valid", wb_valid, 1);
        chk("alu wb_we", wb_we, 1);
        chk("alu wb_addr", wb_addr, 3);
        chk("alu wb_data", wb_data, 5);
        tick();
        @(negedge clk);
        chk("alu pulse end", wb_valid, 0);
        chk("alu hold data", wb_data, 5);

        // Back-to-back non-load requests
        tick();
        req(2'b11, 5'd9, 32'h0000_0007);
        tick();
        req(2'b10, 5'd10, 32'h0000_0044);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b wb_valid", wb_valid, 1);
        chk("b2b wb_data", wb_data, 32'h44);
        chk("b2b wb_addr", wb_addr, 10);

        // Word load, data two cycles after the request
        start_load(2'b10, 1'b0, 2'b11, 5'd4);
        @(negedge clk);
        chk("load busy in_ready", in_ready, 0);
        tick();
        mem_valid = 1'b1;
        ldr_data  = 32'd60000;
        tick();
        mem_valid = 1'b0;
        @(negedge clk);
        chk("word wb_valid", wb_valid, 1);
        chk("word wb_data", wb_data, 32'd60000);
        chk("word wb_addr", wb_addr, 4);
        chk("word in_ready", in_ready, 1);
        tick();
        @(negedge clk);
        chk("word pulse end", wb_valid, 0);

        // Byte / half extraction on 0x0080_FF00
        do_load(2'b00, 1'b1, 2'b10, 5'd5, 32'h0080_FF00, 0);
        chk("sbyte off2", wb_data, 32'hFFFF_FF80);
        do_load(2'b01, 1'b1, 2'b10, 5'd5, 32'h0080_FF00, 0);
        chk("shalf off2", wb_data, 32'h0000_0080);
        do_load(2'b01, 1'b0, 2'b00, 5'd5, 32'h0080_FF00, 0);
        chk("uhalf off0", wb_data, 32'h0000_FF00);
        do_load(2'b01, 1'b1, 2'b00, 5'd6, 32'h0080_FF00, 1);
        chk("shalf off0", wb_data, 32'hFFFF_FF00);
        do_load(2'b01, 1'b1, 2'b11, 5'd6, 32'h8001_1234, 0);
        chk("shalf off3", wb_data, 32'hFFFF_8001);
        do_load(2'b00, 1'b0, 2'b01, 5'd7, 32'h0080_FF00, 2);
        chk("ubyte off1", wb_data, 32'h0000_00FF);
        do_load(2'b00, 1'b1, 2'b11, 5'd7, 32'h8000_0000, 0);
        chk("sbyte off3", wb_data, 32'hFFFF_FF80);
        do_load(2'b11, 1'b1, 2'b10, 5'd8, 32'h89AB_CDEF, 0);
        chk("word ignores off", wb_data, 32'h89AB_CDEF);

        // Timeout: no data for TIMEOUT wait cycles
        start_load(2'b10, 1'b0, 2'b00, 5'd12);
        repeat (TIMEOUT - 2) tick();
        @(negedge clk);
        chk("to cycle15 no err", err_pulse, 0);
        tick();
        @(negedge clk);
        chk("to err_pulse", err_pulse, 1);
        chk("to busy", in_ready, 0);
        tick();
        @(negedge clk);
        chk("to err_pulse end", err_pulse, 0);
        chk("to err_sticky", err_sticky, 1);
        chk("to no wb", wb_valid, 0);
        chk("to in_ready", in_ready, 1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr clears", err_sticky, 0);

        // Data on the last allowed wait cycle wins
        start_load(2'b10, 1'b0, 2'b00, 5'd13);
        repeat (TIMEOUT - 1) tick();
        mem_valid = 1'b1;
        ldr_data  = 32'h1357_9BDF;
        tick();
        mem_valid = 1'b0;
        @(negedge clk);
        chk("late data wb_valid", wb_valid, 1);
        chk("late data wb_data", wb_data, 32'h1357_9BDF);
        chk("late data no sticky", err_sticky, 0);

        // Clear and timeout in the same cycle: timeout wins
        start_load(2'b10, 1'b0, 2'b00, 5'd14);
        repeat (TIMEOUT - 1) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("clr vs timeout", err_sticky, 1);

        // Link write to r0: pulse without write enable
        tick();
        req(2'b10, 5'd0, 32'h0000_0100);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("r0 wb_valid", wb_valid, 1);
        chk("r0 wb_we", wb_we, 0);
        chk("r0 wb_data", wb_data, 32'h100);

        // Reset in the middle of WAIT_LOAD
        start_load(2'b10, 1'b0, 2'b00, 5'd15);
        tick();
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst wb_valid", wb_valid, 0);
        chk("rst wb_addr", wb_addr, 0);
        chk("rst wb_data", wb_data, 0);
        chk("rst err_sticky", err_sticky, 0);
        chk("rst in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        mem_valid = 1'b1;
        ldr_data  = 32'hCAFE_F00D;
        tick();
        tick();
        @(negedge clk);
        chk("post-rst ignore mem wb_valid", wb_valid, 0);
        chk("post-rst wb_data", wb_data, 0);
        chk("post-rst err_pulse", err_pulse, 0);
        chk("post-rst in_ready", in_ready, 1);
        mem_valid = 1'b0;
        tick();
        @(negedge clk);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_load_select.md
WB_LOAD_SELECT -- requirements
Module: wb_load_select

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data path width, a multiple of 16.
REQ-002 The block SHALL have parameter RADDR_W, default 5: destination register address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16: maximum number of WAIT_LOAD cycles, at least 2.
REQ-004 The block SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1: the request fields below are valid.
REQ-007 The block SHALL have port in_ready, output, 1: the block accepts a request this cycle.
REQ-008 The block SHALL have port sel, input, 2: source select; 00 result, 01 load, 10 link_pc, 11 imm.
REQ-009 The block SHALL have ports result, link_pc and imm, input, WIDTH each: the non-load sources.
REQ-010 The block SHALL have port dest, input, RADDR_W: destination register.
REQ-011 The block SHALL have port ld_size, input, 2: load size; 00 byte, 01 half, 10 or 11 word.
REQ-012 The block SHALL have port ld_signed, input, 1: sign-extend (1) or zero-extend (0) the load.
REQ-013 The block SHALL have port byte_off, input, 2: byte offset of the load within the word.
REQ-014 The block SHALL have port mem_valid, input, 1: the load data is present.
REQ-015 The block SHALL have port ldr_data, input, WIDTH: raw memory word.
REQ-016 The block SHALL have port wb_valid, output, 1: a one-cycle writeback pulse.
REQ-017 The block SHALL have port wb_we, output, 1: register write enable.
REQ-018 The block SHALL have port wb_addr, output, RADDR_W: writeback register.
REQ-019 The block SHALL have port wb_data, output, WIDTH: writeback value.
REQ-020 The block SHALL have port err_clr, input, 1: clears err_sticky.
REQ-021 The block SHALL have port err_pulse, output, 1: one-cycle load-timeout indication.
REQ-022 The block SHALL have port err_sticky, output, 1: a timeout has occurred since the last clear or reset.

Function
REQ-023 The block SHALL implement a two-state FSM with states IDLE and WAIT_LOAD.
REQ-024 in_ready SHALL equal 1 exactly when the state is IDLE.
REQ-025 In IDLE, with in_valid=1 and sel not equal to 01, the block SHALL register the selected source into wb_data and dest into wb_addr, and assert wb_valid in the next cycle (latency 1).
REQ-026 In the case of REQ-025 the block SHALL remain in IDLE, so back-to-back requests produce back-to-back wb_valid pulses.
REQ-027 In IDLE, with in_valid=1 and sel=01, the block SHALL capture dest, ld_size, ld_signed and byte_off, clear the timeout counter, and enter WAIT_LOAD.
REQ-028 mem_valid SHALL be ignored outside WAIT_LOAD.
REQ-029 In WAIT_LOAD, with mem_valid=1, the block SHALL register the extracted and extended load value, assert wb_valid in the next cycle, and return to IDLE.
REQ-030 Byte extraction SHALL select ldr_data[8*byte_off+7 : 8*byte_off].
REQ-031 Half extraction SHALL select bits [15:0] when byte_off[1]=0 and bits [31:16] when byte_off[1]=1; byte_off[0] is ignored for halves.
REQ-032 Word extraction SHALL pass ldr_data unchanged and ignore byte_off.
REQ-033 Sign extension SHALL replicate the top extracted bit up to WIDTH-1 when ld_signed=1; otherwise the upper bits SHALL be zero.
REQ-034 In WAIT_LOAD, with mem_valid=0, the counter SHALL increment each cycle.
REQ-035 When the counter equals TIMEOUT-1 with mem_valid=0, the block SHALL pulse err_pulse for one cycle, set err_sticky, return to IDLE, and not assert wb_valid.
REQ-036 When mem_valid=1 in the same cycle the counter reaches TIMEOUT-1, the data SHALL win: normal writeback, no error.
REQ-037 wb_we SHALL equal wb_valid AND (wb_addr != 0), because register 0 is never written.
REQ-038 wb_data and wb_addr SHALL hold their last values while wb_valid=0.
REQ-039 err_clr SHALL clear err_sticky; when err_clr and a timeout occur in the same cycle, err_sticky SHALL end up 1.

Reset
REQ-040 While rst_n=0, the block SHALL immediately enter IDLE and force wb_valid=0, wb_we=0, wb_addr=0, wb_data=0, err_pulse=0, err_sticky=0, and counter=0.
REQ-041 Reset during WAIT_LOAD SHALL abandon the pending load, with no writeback and no error.

Verification
REQ-042 The bench SHALL drive sel=00, result=5, dest=3 -> the next cycle shows wb_valid=1, wb_we=1, wb_addr=3, wb_data=5.
REQ-043 The bench SHALL drive sel=01, dest=4, word size, then mem_valid=1 with ldr_data=60000 two cycles later -> in_ready=0 while waiting, then wb_data=60000 and wb_valid for 1 cycle.
REQ-044 The bench SHALL drive a signed byte load with byte_off=2 and ldr_data=0x0080_FF00, then a signed half load with byte_off=2 on the same data -> wb_data=0xFFFF_FF80, then wb_data=0x0000_0080; an unsigned half load with byte_off=0 on the same data -> wb_data=0x0000_FF00.
REQ-045 The bench SHALL drive sel=01 and never assert mem_valid, with TIMEOUT=16 -> err_pulse in the 16th WAIT_LOAD cycle, err_sticky=1, no wb_valid, and in_ready=1 afterwards; err_clr then clears err_sticky.
REQ-046 The bench SHALL drive sel=10 with dest=0 and link_pc=0x100 -> wb_valid=1, wb_we=0, wb_data=0x100.
REQ-047 The bench SHALL assert rst_n=0 mid-WAIT_LOAD, then assert mem_valid after release -> all outputs are 0, the state is IDLE, and mem_valid is ignored.
